decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have the clock/reset convention: one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, squash the D/E register; sync, same effect as reset on the D/E register only.
REQ-005 SHALL have port EN_REG, input, 1, global pipeline advance enable; low = hold all D/E outputs.
REQ-006 SHALL have port instruction, input, 32, word from fetch.
REQ-007 SHALL have port PCnext, input, 32, fetch PC+4 paired with instruction.
REQ-008 SHALL have port wb_en, input, 1, writeback strobe.
REQ-009 SHALL have port wb_addr, input, 5, writeback register index.
REQ-010 SHALL have port wb_data, input, 32, writeback value.
REQ-011 SHALL have outputs PC_out (32), rs1_data (32), rs2_data (32), imm (32), rd (5), ctrl (ctrl_t), valid (1); all registered D/E.
REQ-012 SHALL have output stall_fetch, 1, combinational load-use hazard; fetch holds PC while high.

Function
REQ-013 SHALL decode fields: opcode=[31:25], dst=[24:20], src1=[19:15], src2=[14:10], imm15=[14:0].
REQ-014 SHALL sign-extend imm15 to 32 bits; branch/jump immediates are not shifted here.
REQ-015 SHALL map opcodes: ADD 0x00, SUB 0x01, MUL 0x02, LDB 0x10, LDW 0x11, STB 0x12, STW 0x13, MOV 0x14, BEQ 0x30, JUMP 0x31, TLBWRITE 0x32, IRET 0x33.
REQ-016 SHALL decode any other opcode as NOP (ctrl all-zero, valid=0).
REQ-017 SHALL contain 32x32 register file; r0 reads 0, writes to r0 ignored.
REQ-018 SHALL perform register-file write at posedge when wb_en=1; two async read ports indexed by src1/src2.
REQ-019 SHALL assert stall_fetch when the D/E register holds valid load (LDB/LDW) with rd!=0 and rd equals a source actually used by the current instruction.
REQ-020 SHALL, on stall_fetch with EN_REG=1, load a bubble (valid=0, ctrl=0) into the D/E register, hold the current instruction, and keep the register file written.
REQ-021 SHALL, on EN_REG=1 without stall, latch the decoded values; latency: instruction at cycle N appears on outputs at N+1.
REQ-022 SHALL, on EN_REG=0, hold the D/E register; register-file writes still occur.
REQ-023 SHALL give flush priority over stall and EN_REG; flush clears D/E (valid=0, outputs 0) and forces stall_fetch=0.
REQ-024 SHALL treat stores as using src1 (base) and dst (data); BEQ as using src1/src2; MOV/JUMP as src1 only.

Reset
REQ-025 SHALL, on reset, clear all D/E outputs to 0, valid=0, and stall_fetch=0.
REQ-026 SHALL, on reset, clear all 32 registers to 0 in the same cycle.
REQ-027 SHALL, on reset mid-stall, drop the stall on the next cycle.

Configuration
REQ-028 SHALL implement write-through bypass when macro DECODE_WB_BYPASS_EN is defined: a read of index==wb_addr with wb_en=1 (index!=0) returns wb_data in the same cycle.
REQ-029 SHALL, without DECODE_WB_BYPASS_EN, return the old register value on a same-cycle read of the written index (the new value is visible next cycle).

Structure
REQ-030 SHALL place opcode localparams, ctrl_t packed struct (reg_write, mem_read, mem_write, byte_access, branch, jump, alu_op[2:0], use_imm) and field bit positions in shared package cpu_pkg.
REQ-031 SHALL instantiate the register file as the sub-module regfile; decode logic and hazard unit remain in decode_stage.

Verification
REQ-032 SHALL cover: reset, then ADD r3,r1,r2 with r1=5, r2=7 preloaded -> next cycle rs1_data=5, rs2_data=7, rd=3, valid=1.
REQ-033 SHALL cover: LDW r4 then ADD r5,r4,r1 -> stall_fetch=1 one cycle, one bubble (valid=0), then ADD issues.
REQ-034 SHALL cover: LDW r0 then ADD using r0 -> no stall; r0 reads 0 after wb of 0xFFFF_FFFF to r0.
REQ-035 SHALL cover: wb_en=1, wb_addr=6, wb_data=0xDEAD_BEEF with same-cycle read of r6 -> 0xDEAD_BEEF with the macro, old value without it.
REQ-036 SHALL cover: flush asserted during stall -> next cycle valid=0, stall_fetch=0.
REQ-037 SHALL cover: imm15=0x4000, EN_REG=0 for 3 cycles -> imm=0xFFFF_C000, outputs held.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode definitions -- instruction field positions, opcodes,
// ALU operation codes and the control bundle carried through the D/E register.
package cpu_pkg;

  // Instruction field bit positions
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 25;
  localparam int DST_MSB  = 24;
  localparam int DST_LSB  = 20;
  localparam int SRC1_MSB = 19;
  localparam int SRC1_LSB = 15;
  localparam int SRC2_MSB = 14;
  localparam int SRC2_LSB = 10;
  localparam int IMM_MSB  = 14;

  // Opcodes
  localparam logic [6:0] OP_ADD      = 7'h00;
  localparam logic [6:0] OP_SUB      = 7'h01;
  localparam logic [6:0] OP_MUL      = 7'h02;
  localparam logic [6:0] OP_LDB      = 7'h10;
  localparam logic [6:0] OP_LDW      = 7'h11;
  localparam logic [6:0] OP_STB      = 7'h12;
  localparam logic [6:0] OP_STW      = 7'h13;
  localparam logic [6:0] OP_MOV      = 7'h14;
  localparam logic [6:0] OP_BEQ      = 7'h30;
  localparam logic [6:0] OP_JUMP     = 7'h31;
  localparam logic [6:0] OP_TLBWRITE = 7'h32;
  localparam logic [6:0] OP_IRET     = 7'h33;

  // ALU operations; address generation for loads/stores/jumps uses ALU_ADD
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;
  localparam logic [2:0] ALU_TLB  = 3'd4;
  localparam logic [2:0] ALU_IRET = 3'd5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       byte_access;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
    logic       use_imm;
  } ctrl_t;

  function automatic logic [31:0] sext15(input logic [14:0] v);
    return {{17{v[14]}}, v};
  endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, one write port, two asynchronous read ports.
// r0 always reads zero and ignores writes.
// Build option: define DECODE_WB_BYPASS_EN to make a same-cycle write visible
// on the read ports (write-through); otherwise the old value is read.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b
);

  logic [31:0] regs [32];
  logic        byp_a;
  logic        byp_b;

  // Storage: full clear on reset, otherwise write on strobe (r0 excluded)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign byp_a = wb_en && (wb_addr != 5'd0) && (wb_addr == rd_addr_a);
  assign byp_b = wb_en && (wb_addr != 5'd0) && (wb_addr == rd_addr_b);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  // Read ports: r0 forced to zero, optional write-through
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (byp_a) rd_data_a = wb_data;
    if (byp_b) rd_data_b = wb_data;
    if (rd_addr_a == 5'd0) rd_data_a = '0;
    if (rd_addr_b == 5'd0) rd_data_b = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with D/E pipeline register, load-use hazard
// detection and the register file.
// Build option: DECODE_WB_BYPASS_EN enables register-file write-through.
module decode_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        EN_REG,
  input  logic [31:0] instruction,
  input  logic [31:0] PCnext,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] PC_out,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output ctrl_t       ctrl,
  output logic        valid,
  output logic        stall_fetch
);

  logic [6:0]  opcode;
  logic [4:0]  dst;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [14:0] imm15;
  ctrl_t       dec_ctrl;
  logic        dec_valid;
  logic        use_src1;
  logic        use_src2;
  logic        use_dst;
  logic [4:0]  rd_addr_b;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic        hazard;
  logic        de_clear;

  assign opcode = instruction[OPC_MSB:OPC_LSB];
  assign dst    = instruction[DST_MSB:DST_LSB];
  assign src1   = instruction[SRC1_MSB:SRC1_LSB];
  assign src2   = instruction[SRC2_MSB:SRC2_LSB];
  assign imm15  = instruction[IMM_MSB:0];

  // Opcode decode: control bundle plus the register fields actually read
  always_comb begin
    dec_ctrl  = '0;
    dec_valid = 1'b1;
    use_src1  = 1'b0;
    use_src2  = 1'b0;
    use_dst   = 1'b0;
    case (opcode)
      OP_ADD: begin
        dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = ALU_ADD;
        use_src1 = 1'b1; use_src2 = 1'b1;
      end
      OP_SUB: begin
        dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = ALU_SUB;
        use_src1 = 1'b1; use_src2 = 1'b1;
      end
      OP_MUL: begin
        dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = ALU_MUL;
        use_src1 = 1'b1; use_src2 = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.mem_read    = 1'b1;
        dec_ctrl.byte_access = (opcode == OP_LDB);
        dec_ctrl.alu_op      = ALU_ADD;
        dec_ctrl.use_imm     = 1'b1;
        use_src1 = 1'b1;
      end
      OP_STB, OP_STW: begin
        dec_ctrl.mem_write   = 1'b1;
        dec_ctrl.byte_access = (opcode == OP_STB);
        dec_ctrl.alu_op      = ALU_ADD;
        dec_ctrl.use_imm     = 1'b1;
        use_src1 = 1'b1; use_dst = 1'b1;
      end
      OP_MOV: begin
        dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = ALU_PASS;
        use_src1 = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1; dec_ctrl.alu_op = ALU_SUB;
        use_src1 = 1'b1; use_src2 = 1'b1;
      end
      OP_JUMP: begin
        dec_ctrl.jump = 1'b1; dec_ctrl.alu_op = ALU_ADD; dec_ctrl.use_imm = 1'b1;
        use_src1 = 1'b1;
      end
      OP_TLBWRITE: begin
        dec_ctrl.alu_op = ALU_TLB;
        use_src1 = 1'b1; use_src2 = 1'b1;
      end
      OP_IRET: begin
        dec_ctrl.alu_op = ALU_IRET;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  // Stores carry their data register in the dst field, so port B reads it there
  assign rd_addr_b = dec_ctrl.mem_write ? dst : src2;

  regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_addr_a (src1),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b)
  );

  assign hazard = valid && ctrl.mem_read && (rd != 5'd0) &&
                  ((use_src1 && (src1 == rd)) ||
                   (use_src2 && (src2 == rd)) ||
                   (use_dst  && (dst  == rd)));

  assign stall_fetch = hazard && !reset && !flush;

  // A stalled advance turns into a bubble; reset and flush win over everything
  assign de_clear = reset || flush || (EN_REG && stall_fetch);

  // D/E register: clear or bubble, else advance when enabled, else hold
  always_ff @(posedge clk) begin
    if (de_clear) begin
      PC_out   <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      imm      <= '0;
      rd       <= '0;
      ctrl     <= '0;
      valid    <= 1'b0;
    end else if (EN_REG) begin
      PC_out   <= PCnext;
      rs1_data <= rf_a;
      rs2_data <= rf_b;
      imm      <= sext15(imm15);
      rd       <= dst;
      ctrl     <= dec_ctrl;
      valid    <= dec_valid;
    end
  end

endmodule
